path_metric_unit: RTL and testbench

PATH_METRIC_UNIT -- requirements
Module: path_metric_unit

---
 rtl/path_metric_unit.sv | 158 +++++++++++++++
 tb/tb_path_metric_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/path_metric_unit.sv
// rtl/path_metric_unit.sv - 4-state K=3 Viterbi add-compare-select path metric unit
// Define ACS_NORM_EN to subtract 128 from all metrics once they all reach it; default saturates at 255.
module path_metric_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        init,
    input  logic [1:0]  bm_s0_path0,
    input  logic [1:0]  bm_s0_path1,
    input  logic [1:0]  bm_s1_path0,
    input  logic [1:0]  bm_s1_path1,
    input  logic [1:0]  bm_s2_path0,
    input  logic [1:0]  bm_s2_path1,
    input  logic [1:0]  bm_s3_path0,
    input  logic [1:0]  bm_s3_path1,
    output logic [3:0]  dec_out,
    output logic        out_valid,
    output logic [1:0]  best_state,
    output logic [7:0]  pm_best,
    output logic [15:0] sym_count
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [7:0] PM_START = 8'd64;

    state_t      r_state;
    logic [7:0]  r_pm [4];
    logic [3:0]  r_dec;
    logic        r_out_valid;
    logic [1:0]  r_best_state;
    logic [7:0]  r_pm_best;
    logic [15:0] r_sym_count;

    logic [1:0]  w_bm0 [4];
    logic [1:0]  w_bm1 [4];
    logic [7:0]  w_old_pm [4];
    logic [8:0]  w_cand_a [4];
    logic [8:0]  w_cand_b [4];
    logic [8:0]  w_min [4];
    logic [7:0]  w_new [4];
    logic [3:0]  w_dec;
    logic [1:0]  w_best_idx;
    logic [7:0]  w_best_pm;
    logic [1:0]  w_bm_a;
    logic [1:0]  w_bm_b;
`ifdef ACS_NORM_EN
    logic        w_norm;
    logic [8:0]  w_adj;
`endif

    assign w_bm0[0] = bm_s0_path0;
    assign w_bm0[1] = bm_s1_path0;
    assign w_bm0[2] = bm_s2_path0;
    assign w_bm0[3] = bm_s3_path0;
    assign w_bm1[0] = bm_s0_path1;
    assign w_bm1[1] = bm_s1_path1;
    assign w_bm1[2] = bm_s2_path1;
    assign w_bm1[3] = bm_s3_path1;

    // A frame restart (or a fresh frame in IDLE) feeds the ACS from the start metrics.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (init || (r_state == IDLE)) begin
                w_old_pm[n] = (n == 0) ? 8'd0 : PM_START;
            end else begin
                w_old_pm[n] = r_pm[n];
            end
        end
    end

    // Predecessors of next state ns are {ns[0],0} and {ns[0],1}; ns[1] is the input bit.
    always_comb begin
        w_dec  = 4'd0;
        w_bm_a = 2'd0;
        w_bm_b = 2'd0;
        for (int n = 0; n < 4; n++) begin
            w_bm_a      = n[1] ? w_bm1[{n[0], 1'b0}] : w_bm0[{n[0], 1'b0}];
            w_bm_b      = n[1] ? w_bm1[{n[0], 1'b1}] : w_bm0[{n[0], 1'b1}];
            w_cand_a[n] = {1'b0, w_old_pm[{n[0], 1'b0}]} + {7'd0, w_bm_a};
            w_cand_b[n] = {1'b0, w_old_pm[{n[0], 1'b1}]} + {7'd0, w_bm_b};
            w_dec[n]    = (w_cand_b[n] < w_cand_a[n]);
            w_min[n]    = w_dec[n] ? w_cand_b[n] : w_cand_a[n];
        end
    end

`ifdef ACS_NORM_EN
    always_comb begin
        w_norm = (w_min[0] >= 9'd128) && (w_min[1] >= 9'd128) &&
                 (w_min[2] >= 9'd128) && (w_min[3] >= 9'd128);
        w_adj  = 9'd0;
        for (int n = 0; n < 4; n++) begin
            w_adj    = w_norm ? (w_min[n] - 9'd128) : w_min[n];
            w_new[n] = w_adj[8] ? 8'hFF : w_adj[7:0];
        end
    end
`else
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_new[n] = w_min[n][8] ? 8'hFF : w_min[n][7:0];
        end
    end
`endif

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_idx = 2'd0;
        w_best_pm  = w_new[0];
        for (int n = 1; n < 4; n++) begin
            if (w_new[n] < w_best_pm) begin
                w_best_pm  = w_new[n];
                w_best_idx = n[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pm[0]      <= 8'd0;
            r_pm[1]      <= PM_START;
            r_pm[2]      <= PM_START;
            r_pm[3]      <= PM_START;
            r_dec        <= 4'd0;
            r_out_valid  <= 1'b0;
            r_best_state <= 2'd0;
            r_pm_best    <= 8'd0;
            r_sym_count  <= 16'd0;
        end else if (in_valid) begin
            r_state      <= RUN;
            r_pm         <= w_new;
            r_dec        <= w_dec;
            r_out_valid  <= 1'b1;
            r_best_state <= w_best_idx;
            r_pm_best    <= w_best_pm;
            if (init) begin
                r_sym_count <= 16'd1;
            end else if (r_sym_count != 16'hFFFF) begin
                r_sym_count <= r_sym_count + 16'd1;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (init) begin
                r_state     <= IDLE;
                r_pm[0]     <= 8'd0;
                r_pm[1]     <= PM_START;
                r_pm[2]     <= PM_START;
                r_pm[3]     <= PM_START;
                r_sym_count <= 16'd0;
            end
        end
    end

    assign dec_out    = r_dec;
    assign out_valid  = r_out_valid;
    assign best_state = r_best_state;
    assign pm_best    = r_pm_best;
    assign sym_count  = r_sym_count;

endmodule

// File: tb/tb_path_metric_unit.sv
// tb/tb_path_metric_unit.sv - self-checking bench for path_metric_unit (honours ACS_NORM_EN)
module tb_path_metric_unit;
    logic        clk = 1'b0;
    logic        rst, in_valid, init;
    logic [15:0] bms;
    logic [3:0]  dec_out;
    logic        out_valid;
    logic [1:0]  best_state;
    logic [7:0]  pm_best;
    logic [15:0] sym_count;

    always #5 clk = ~clk;

    path_metric_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .init        (init),
        .bm_s0_path0 (bms[1:0]),
        .bm_s0_path1 (bms[3:2]),
        .bm_s1_path0 (bms[5:4]),
        .bm_s1_path1 (bms[7:6]),
        .bm_s2_path0 (bms[9:8]),
        .bm_s2_path1 (bms[11:10]),
        .bm_s3_path0 (bms[13:12]),
        .bm_s3_path1 (bms[15:14]),
        .dec_out     (dec_out),
        .out_valid   (out_valid),
        .best_state  (best_state),
        .pm_best     (pm_best),
        .sym_count   (sym_count)
    );

    typedef struct {
        logic        r, i, v;
        logic [15:0] b;
        logic [3:0]  dec;
        logic        ov;
        logic [1:0]  best;
        logic [7:0]  pmb;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: forward trellis walk over every (state, bit) branch.
    int m_pm[4];
    int m_dec, m_ov, m_best, m_pmb, m_cnt;

    task automatic model_step(input logic r, input logic i, input logic v, input logic [15:0] b);
        int old[4];
        int ca[4];
        int cb[4];
        int nw[4];
        int ns, c;
        if (r) begin
            m_pm = '{0, 64, 64, 64};
            m_dec = 0; m_ov = 0; m_best = 0; m_pmb = 0; m_cnt = 0;
            return;
        end
        if (!v) begin
            m_ov = 0;
            if (i) begin
                m_pm  = '{0, 64, 64, 64};
                m_cnt = 0;
            end
            return;
        end
        if (i) old = '{0, 64, 64, 64};
        else   old = m_pm;
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns = 2 * u + s / 2;
                c  = old[s] + int'(b[(s * 2 + u) * 2 +: 2]);
                if (s % 2 == 0) ca[ns] = c;
                else            cb[ns] = c;
            end
        end
        m_dec = 0;
        for (int k = 0; k < 4; k++) begin
            nw[k] = (cb[k] < ca[k]) ? cb[k] : ca[k];
            if (cb[k] < ca[k]) m_dec = m_dec + (1 << k);
        end
`ifdef ACS_NORM_EN
        if (nw[0] >= 128 && nw[1] >= 128 && nw[2] >= 128 && nw[3] >= 128)
            for (int k = 0; k < 4; k++) nw[k] = nw[k] - 128;
`endif
        for (int k = 0; k < 4; k++) if (nw[k] > 255) nw[k] = 255;
        m_pm  = nw;
        m_best = 0;
        m_pmb  = nw[0];
        for (int k = 1; k < 4; k++) if (nw[k] < m_pmb) begin m_pmb = nw[k]; m_best = k; end
        m_ov  = 1;
        m_cnt = i ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] d, input logic ov,
                             input logic [1:0] bs, input logic [7:0] pb, input logic [15:0] cn);
        check({tag, ".dec_out"},    {28'd0, dec_out},    {28'd0, d});
        check({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, ov});
        check({tag, ".best_state"}, {30'd0, best_state}, {30'd0, bs});
        check({tag, ".pm_best"},    {24'd0, pm_best},    {24'd0, pb});
        check({tag, ".sym_count"},  {16'd0, sym_count},  {16'd0, cn});
    endtask

    task automatic step(input logic r, input logic i, input logic v, input logic [15:0] b);
        rst = r; init = i; in_valid = v; bms = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic r, input logic i, input logic v, input logic [15:0] b,
                       input logic [3:0] d, input logic ov, input logic [1:0] bs,
                       input logic [7:0] pb, input logic [15:0] cn);
        vec_t e;
        e.r = r; e.i = i; e.v = v; e.b = b;
        e.dec = d; e.ov = ov; e.best = bs; e.pmb = pb; e.cnt = cn;
        tbl.push_back(e);
    endtask

    function automatic logic [15:0] rand_bms(input int lo);
        logic [15:0] b;
        for (int k = 0; k < 8; k++) b[k * 2 +: 2] = 2'($urandom_range(lo, 2));
        return b;
    endfunction

    initial begin
        int nsym;
        logic r, i, v;
        logic [15:0] b;

        rst = 1'b1; init = 1'b0; in_valid = 1'b0; bms = 16'd0;
        @(negedge clk);

        //   r  i  v  bms        dec   ov  best pmb  cnt
        add(1, 0, 0, 16'h0000, 4'h0, 0, 0, 0,   0);
        add(0, 0, 1, 16'h8888, 4'h0, 1, 0, 0,   1);
        add(0, 0, 0, 16'h0000, 4'h0, 0, 0, 0,   1);
        add(1, 0, 0, 16'h0000, 4'h0, 0, 0, 0,   0);
        add(0, 0, 1, 16'hAAAA, 4'h0, 1, 0, 2,   1);
        add(0, 0, 1, 16'hAAAA, 4'h0, 1, 0, 4,   2);
        add(0, 0, 1, 16'hAA8A, 4'h1, 1, 0, 4,   3);
        add(0, 0, 0, 16'h1234, 4'h1, 0, 0, 4,   3);
        add(0, 0, 0, 16'h0000, 4'h1, 0, 0, 4,   3);
        add(0, 0, 0, 16'hFFFF, 4'h1, 0, 0, 4,   3);
        add(0, 0, 1, 16'h0000, 4'h0, 1, 0, 4,   4);
        add(0, 1, 1, 16'h0000, 4'h0, 1, 0, 0,   1);
        add(0, 1, 0, 16'h0000, 4'h0, 0, 0, 0,   0);
        add(0, 0, 1, 16'h2222, 4'h0, 1, 2, 0,   1);
        add(0, 0, 0, 16'h0000, 4'h0, 0, 2, 0,   1);
        add(1, 0, 1, 16'h0000, 4'h0, 0, 0, 0,   0);
        add(0, 0, 1, 16'h8888, 4'h0, 1, 0, 0,   1);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].i, tbl[k].v, tbl[k].b);
            check_all($sformatf("tbl%0d", k), tbl[k].dec, tbl[k].ov, tbl[k].best, tbl[k].pmb, tbl[k].cnt);
        end

        // Long all-2 run: normalization or saturation boundary.
`ifdef ACS_NORM_EN
        nsym = 64;
`else
        nsym = 128;
`endif
        step(1, 0, 0, 16'h0000);
        for (int k = 1; k <= nsym; k++) begin
            step(0, 0, 1, 16'hAAAA);
            if (k == 63) check("run63.pm_best", {24'd0, pm_best}, 32'd126);
        end
`ifdef ACS_NORM_EN
        check_all("run_end", 4'h0, 1, 0, 8'd0, 16'd64);
        step(0, 0, 1, 16'hAAAA);
        check("run_after.pm_best", {24'd0, pm_best}, 32'd2);
`else
        check_all("run_end", 4'h0, 1, 0, 8'd255, 16'd128);
        step(0, 0, 1, 16'hAAAA);
        check("run_after.pm_best", {24'd0, pm_best}, 32'd255);
`endif

        // Randomized traffic against the reference model.
        step(1, 0, 0, 16'h0000);
        model_step(1, 0, 0, 16'h0000);
        for (int k = 0; k < 4500; k++) begin
            if (k < 3000) begin
                r = ($urandom_range(0, 199) == 0);
                i = ($urandom_range(0, 99) == 0);
                b = rand_bms(0);
            end else begin
                r = 1'b0;
                i = ($urandom_range(0, 499) == 0);
                b = rand_bms(1);
            end
            v = ($urandom_range(0, 9) < 7);
            step(r, i, v, b);
            model_step(r, i, v, b);
            check_all($sformatf("rnd%0d", k), 4'(m_dec), 1'(m_ov), 2'(m_best), 8'(m_pmb), 16'(m_cnt));
        end

        // Symbol counter saturation.
        step(1, 0, 0, 16'h0000);
        for (int k = 0; k < 65536; k++) step(0, 0, 1, 16'hAAAA);
        check("satcnt.sym_count", {16'd0, sym_count}, 32'd65535);
        step(0, 0, 1, 16'hAAAA);
        check("satcnt2.sym_count", {16'd0, sym_count}, 32'd65535);
        check("satcnt2.out_valid", {31'd0, out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
